// File: rtl/param_register_file_if.sv
`default_nettype none
// ============================================================================
// Module  : param_register_file_if
// Brief   : Read/write/clear bus bundle for param_register_file.
// Revision: 1.0
// ============================================================================
interface param_register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] Rs;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] AR;
  logic [DATA_W-1:0] BR;
  logic              regWrite;
  logic [ADDR_W-1:0] writeRegister;
  logic [DATA_W-1:0] writeData;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  logic              write_err;

  modport master (
    output Rs, Rd, regWrite, writeRegister, writeData, clear_req,
    input  AR, BR, clear_busy, clear_done, write_err
  );

  modport slave (
    input  Rs, Rd, regWrite, writeRegister, writeData, clear_req,
    output AR, BR, clear_busy, clear_done, write_err
  );
endinterface
`default_nettype wire

// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module  : param_register_file
// Brief   : 2R/1W register file with optional zero register, bulk-clear
//           engine and dropped-write reporting. Macro REGFILE_BYPASS_EN
//           enables same-cycle write-to-read forwarding.
// Revision: 1.0
// ============================================================================
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  wire logic           clock,
  input  wire logic           reset,
  param_register_file_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_index;
  logic [DATA_W-1:0] r_mem [NREGS];
  logic              r_busy;
  logic              r_done;
  logic              r_werr;

  logic w_write_zero;
  logic w_write_ok;
  logic w_write_drop;
  logic w_fwd_ok;

  // Writes to a hardwired-zero entry 0 vanish silently and are never errors.
  assign w_write_zero = (ZERO_REG != 0) && (bus.writeRegister == '0);
  assign w_write_ok   = bus.regWrite && (r_state != S_CLEAR) && !w_write_zero;
  assign w_write_drop = bus.regWrite && (r_state == S_CLEAR) && !w_write_zero;

`ifdef REGFILE_BYPASS_EN
  assign w_fwd_ok = w_write_ok;
`else
  assign w_fwd_ok = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      r_state <= S_IDLE;
      r_index <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_werr  <= 1'b0;
    end else begin
      r_werr <= w_write_drop;
      if (w_write_ok) r_mem[bus.writeRegister] <= bus.writeData;
      case (r_state)
        S_IDLE: begin
          if (bus.clear_req) begin
            r_state <= S_CLEAR;
            r_index <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_mem[r_index] <= '0;
          r_index        <= r_index + 1'b1;
          if (r_index == ADDR_W'(NREGS - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.AR = r_mem[bus.Rs];
    if (w_fwd_ok && (bus.Rs == bus.writeRegister)) bus.AR = bus.writeData;
    if ((ZERO_REG != 0) && (bus.Rs == '0)) bus.AR = '0;
  end

  always_comb begin
    bus.BR = r_mem[bus.Rd];
    if (w_fwd_ok && (bus.Rd == bus.writeRegister)) bus.BR = bus.writeData;
    if ((ZERO_REG != 0) && (bus.Rd == '0)) bus.BR = '0;
  end

  assign bus.clear_busy = r_busy;
  assign bus.clear_done = r_done;
  assign bus.write_err  = r_werr;
endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
// Module  : tb_param_register_file
// Brief   : Randomised self-checking bench with a behavioural register model.
// Revision: 1.0
// ============================================================================
module tb_param_register_file;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  param_register_file_if #(.DATA_W(16), .ADDR_W(3)) bus  ();
  param_register_file_if #(.DATA_W(16), .ADDR_W(3)) zbus ();

  param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
  param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset(reset), .bus(zbus.slave));

  always #10 clock = ~clock;

  // Model: register contents plus clear progress (0 idle, 1..8 clearing
  // entry phase-1, 9 done pulse).
  logic [15:0] m_mem [8];
  int          m_phase;
  logic        m_werr;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    m_phase = 0;
    m_werr  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [2:0] save_rs, save_rd;
    checks++;
    if (bus.clear_busy !== (m_phase >= 1 && m_phase <= 8)) begin
      errors++;
      $display("FAIL %s busy: got %b expected %b", tag, bus.clear_busy, (m_phase >= 1 && m_phase <= 8));
    end
    checks++;
    if (bus.clear_done !== (m_phase == 9)) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", tag, bus.clear_done, (m_phase == 9));
    end
    checks++;
    if (bus.write_err !== m_werr) begin
      errors++;
      $display("FAIL %s write_err: got %b expected %b", tag, bus.write_err, m_werr);
    end
    save_rs = bus.Rs;
    save_rd = bus.Rd;
    for (int i = 0; i < 8; i++) begin
      bus.Rs = 3'(i);
      bus.Rd = 3'(7 - i);
      #1;
      checks++;
      if (bus.AR !== m_mem[i]) begin
        errors++;
        $display("FAIL %s AR[%0d]: got %h expected %h", tag, i, bus.AR, m_mem[i]);
      end
      checks++;
      if (bus.BR !== m_mem[7-i]) begin
        errors++;
        $display("FAIL %s BR[%0d]: got %h expected %h", tag, 7 - i, bus.BR, m_mem[7-i]);
      end
    end
    bus.Rs = save_rs;
    bus.Rd = save_rd;
  endtask

  // Advance one clock edge, updating the model from the inputs present at it.
  task automatic tick(input string tag);
    logic [15:0] nm [8];
    int          np;
    logic        drop;
    nm   = m_mem;
    np   = m_phase;
    drop = bus.regWrite && (m_phase >= 1 && m_phase <= 8);
    if (bus.regWrite && (m_phase == 0 || m_phase == 9)) nm[bus.writeRegister] = bus.writeData;
    if (m_phase >= 1 && m_phase <= 8) begin
      nm[m_phase-1] = 16'h0000;
      np = m_phase + 1;
    end else if (m_phase == 9) begin
      np = 0;
    end else if (bus.clear_req) begin
      np = 1;
    end
    @(posedge clock);
    #1;
    m_mem   = nm;
    m_phase = np;
    m_werr  = drop;
    bus.regWrite = 1'b0;
    check_state(tag);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d, input string tag);
    bus.regWrite      = 1'b1;
    bus.writeRegister = a;
    bus.writeData     = d;
    tick(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_state("reset");
    #1 reset = 1'b0;
    tick("reset_release");
  endtask

  task automatic test_write_read();
    write_reg(3'd5, 16'hBEEF, "wr_r5");
    bus.regWrite = 1'b1; bus.writeRegister = 3'd2; bus.writeData = 16'h1234;
    bus.Rs = 3'd2; bus.Rd = 3'd5;
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (bus.AR !== 16'h1234) begin
      errors++;
      $display("FAIL same_cycle_r2: got %h expected %h", bus.AR, 16'h1234);
    end
`else
    if (bus.AR !== 16'h0000) begin
      errors++;
      $display("FAIL same_cycle_r2: got %h expected %h", bus.AR, 16'h0000);
    end
`endif
    tick("wr_r2");
    bus.Rs = 3'd5; bus.Rd = 3'd2;
    #1;
    checks++;
    if (bus.AR !== 16'hBEEF || bus.BR !== 16'h1234) begin
      errors++;
      $display("FAIL read_r5_r2: got %h/%h expected beef/1234", bus.AR, bus.BR);
    end
  endtask

  task automatic test_random_traffic();
    for (int c = 0; c < 30; c++) begin
      bus.regWrite      = 1'($urandom_range(0, 1));
      bus.writeRegister = 3'($urandom_range(0, 7));
      bus.writeData     = 16'($urandom);
      tick("random");
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_at  = -1;
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(16'h1111 * (i + 1)), "fill");
    bus.clear_req = 1'b1;
    tick("clear_start");
    bus.clear_req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.clear_busy) busy_cnt++;
      if (bus.clear_done) done_at = c;
      if (c == 4 || c == 5) begin
        bus.Rs = 3'd3;
        #1;
        checks++;
        if (bus.AR !== ((c == 4) ? 16'h4444 : 16'h0000)) begin
          errors++;
          $display("FAIL r3_at_E+%0d: got %h expected %h", c, bus.AR, ((c == 4) ? 16'h4444 : 16'h0000));
        end
      end
      if (c < 10) tick("clearing");
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL busy_len: got %0d expected 8", busy_cnt);
    end
    checks++;
    if (done_at != 9) begin
      errors++;
      $display("FAIL done_cycle: got %0d expected 9", done_at);
    end
  endtask

  task automatic test_write_during_clear();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(16'h0101 * (i + 3)), "refill");
    bus.clear_req = 1'b1;
    tick("clear2_start");
    bus.clear_req = 1'b0;
    write_reg(3'd1, 16'hAAAA, "drop_write");
    checks++;
    if (bus.write_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_err: got %b expected 1", bus.write_err);
    end
    tick("drop_after");
    for (int c = 0; c < 12 && m_phase != 9; c++) tick("to_done");
    write_reg(3'd1, 16'hAAAA, "done_write");
    bus.Rs = 3'd1;
    #1;
    checks++;
    if (bus.AR !== 16'hAAAA || bus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL done_write: got %h err=%b expected aaaa err=0", bus.AR, bus.write_err);
    end
  endtask

  task automatic test_back_to_back_clear();
    int dones = 0;
    write_reg(3'd6, 16'h5A5A, "pre_held");
    bus.regWrite = 1'b1; bus.writeRegister = 3'd7; bus.writeData = 16'hC3C3;
    bus.clear_req = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick("held");
      if (bus.clear_done) dones++;
    end
    bus.clear_req = 1'b0;
    for (int c = 0; c < 12; c++) tick("held_drain");
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL held_done_count: got %0d expected 2", dones);
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'(16'h0F0F + i), "prefill");
    bus.clear_req = 1'b1;
    tick("rst_clear_start");
    bus.clear_req = 1'b0;
    tick("rst_e2");
    tick("rst_e3");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_state("mid_reset");
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #1;
      check_state("held_reset");
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) tick("post_reset");
    write_reg(3'd4, 16'h7777, "post_reset_wr");
    bus.clear_req = 1'b1;
    tick("reclear_start");
    bus.clear_req = 1'b0;
    for (int c = 0; c < 10; c++) tick("reclear");
  endtask

  task automatic test_zero_reg();
    zbus.regWrite = 1'b1; zbus.writeRegister = 3'd0; zbus.writeData = 16'hFFFF;
    @(posedge clock);
    #1;
    zbus.regWrite = 1'b1; zbus.writeRegister = 3'd3; zbus.writeData = 16'h1357;
    zbus.Rs = 3'd0;
    #1;
    checks++;
    if (zbus.AR !== 16'h0000) begin
      errors++;
      $display("FAIL zero_r0: got %h expected 0000", zbus.AR);
    end
    checks++;
    if (zbus.write_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_err: got %b expected 0", zbus.write_err);
    end
    @(posedge clock);
    #1;
    zbus.regWrite = 1'b0;
    zbus.Rs = 3'd3; zbus.Rd = 3'd0;
    #1;
    checks++;
    if (zbus.AR !== 16'h1357 || zbus.BR !== 16'h0000) begin
      errors++;
      $display("FAIL zero_r3: got %h/%h expected 1357/0000", zbus.AR, zbus.BR);
    end
  endtask

  initial begin
    bus.Rs = '0; bus.Rd = '0; bus.regWrite = 1'b0; bus.writeRegister = '0;
    bus.writeData = '0; bus.clear_req = 1'b0;
    zbus.Rs = '0; zbus.Rd = '0; zbus.regWrite = 1'b0; zbus.writeRegister = '0;
    zbus.writeData = '0; zbus.clear_req = 1'b0;
    model_reset();
    test_reset();
    test_write_read();
    test_random_traffic();
    test_clear();
    test_write_during_clear();
    test_back_to_back_clear();
    test_reset_mid_clear();
    test_zero_reg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
